// File: rtl/dht11_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the DHT11 reply decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dht11_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RESP = 3'd1,
        S_RESP_LOW  = 3'd2,
        S_RESP_HIGH = 3'd3,
        S_BIT_LOW   = 3'd4,
        S_BIT_HIGH  = 3'd5,
        S_CHECK     = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RESP_TO = 2'd1;
    localparam logic [1:0] ERR_BIT_TO  = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam int FRAME_W = 40;

    // Byte positions in arrival order; byte 0 arrives first (MSB of the frame).
    localparam int BYTE_HUM_INT  = 0;
    localparam int BYTE_HUM_DEC  = 1;
    localparam int BYTE_TEMP_INT = 2;
    localparam int BYTE_TEMP_DEC = 3;
    localparam int BYTE_CSUM     = 4;

    // Extract byte idx (arrival order) from the assembled frame.
    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame, input int idx);
        logic [FRAME_W-1:0] sh;
        sh = frame << (8 * idx);
        return sh[FRAME_W-1 -: 8];
    endfunction

endpackage

// File: rtl/dht11_frame_receiver_pulse_timer.sv
`timescale 1ns/1ps
// Synchronises the DHT11 line, detects edges and times each phase.
// Latency: 2 cycles line->sync, edge flags valid the cycle sync changes.
// Backpressure: none; free-running, counter saturates.
module dht11_pulse_timer #(
    parameter int CNT_W         = 16,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dht11_in,
    input  logic             clear,
    input  logic             active,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TO_TICKS = CNT_W'(TIMEOUT_TICKS);

    logic sync1;
    logic sync2;
    logic line_prev;

    // Two-flop synchroniser plus one history flop; idle bus is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= dht11_in;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign rise = sync2 & ~line_prev;
    assign fall = ~sync2 & line_prev;

    // Phase length counter: restarts on any edge or state change, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || rise || fall) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = active && (cnt == TO_TICKS);

endmodule

// File: rtl/dht11_frame_receiver.sv
`timescale 1ns/1ps
// Decodes the 40-bit DHT11 reply, verifies checksum, presents sensor bytes.
// Latency: data_valid/frame_err 2 cycles after the final decoding edge at sync output.
// Backpressure: none; strobes are single-cycle, start_done ignored while busy.
module dht11_frame_receiver
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US     = 1,
    parameter int BIT1_THRESH_US = 50,
    parameter int TIMEOUT_US     = 200,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_done,
    input  logic       dht11_in,
    output logic       busy,
    output logic       data_valid,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec
);

    // The counter is cleared on the edge that opens a phase, so at the closing
    // edge it reads (phase length - 1). ">= threshold" therefore decodes a
    // high phase strictly longer than the threshold as a 1.
    localparam logic [CNT_W-1:0] BIT1_TICKS = CNT_W'(BIT1_THRESH_US * CLK_PER_US);

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] shift_reg;
    logic [5:0]         bit_idx;
    logic               rise;
    logic               fall;
    logic               timeout;
    logic [CNT_W-1:0]   cnt;
    logic               active;
    logic               state_chg;
    logic               start_acc;
    logic               shift_en;
    logic               err_set;
    logic [1:0]         err_nxt;
    logic               bit_val;
    logic               last_bit;
    logic [7:0]         csum;
    logic               csum_ok;

    assign active    = (state != S_IDLE) && (state != S_CHECK) && (state != S_ERR);
    assign state_chg = (state_nxt != state);
    assign bit_val   = (cnt >= BIT1_TICKS);
    assign last_bit  = (bit_idx == 6'(FRAME_W - 1));
    assign csum      = frame_byte(shift_reg, BYTE_HUM_INT) + frame_byte(shift_reg, BYTE_HUM_DEC)
                     + frame_byte(shift_reg, BYTE_TEMP_INT) + frame_byte(shift_reg, BYTE_TEMP_DEC);
    assign csum_ok   = (csum == frame_byte(shift_reg, BYTE_CSUM));

    dht11_pulse_timer #(
        .CNT_W         (CNT_W),
        .TIMEOUT_TICKS (TIMEOUT_US * CLK_PER_US)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .dht11_in (dht11_in),
        .clear    (state_chg),
        .active   (active),
        .rise     (rise),
        .fall     (fall),
        .cnt      (cnt),
        .timeout  (timeout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; timeout wins over a coincident edge.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        shift_en  = 1'b0;
        err_set   = 1'b0;
        err_nxt   = ERR_NONE;
        unique case (state)
            S_IDLE: begin
                if (start_done) begin
                    state_nxt = S_WAIT_RESP;
                    start_acc = 1'b1;
                end
            end
            S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH: begin
                if (timeout) begin
                    state_nxt = S_ERR;
                    err_set   = 1'b1;
                    err_nxt   = ERR_RESP_TO;
                end else if (state == S_WAIT_RESP && fall) begin
                    state_nxt = S_RESP_LOW;
                end else if (state == S_RESP_LOW && rise) begin
                    state_nxt = S_RESP_HIGH;
                end else if (state == S_RESP_HIGH && fall) begin
                    state_nxt = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                if (timeout) begin
                    state_nxt = S_ERR;
                    err_set   = 1'b1;
                    err_nxt   = ERR_BIT_TO;
                end else if (rise) begin
                    state_nxt = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                if (timeout) begin
                    state_nxt = S_ERR;
                    err_set   = 1'b1;
                    err_nxt   = ERR_BIT_TO;
                end else if (fall) begin
                    shift_en  = 1'b1;
                    state_nxt = last_bit ? S_CHECK : S_BIT_LOW;
                end
            end
            S_CHECK: begin
                if (csum_ok) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_ERR;
                    err_set   = 1'b1;
                    err_nxt   = ERR_CSUM;
                end
            end
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame assembly, status and output registers; data bytes only move on a good checksum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg  <= '0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            hum_int    <= '0;
            hum_dec    <= '0;
            temp_int   <= '0;
            temp_dec   <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (start_acc) begin
                busy      <= 1'b1;
                err_code  <= ERR_NONE;
                shift_reg <= '0;
                bit_idx   <= '0;
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], bit_val};
                bit_idx   <= bit_idx + 6'd1;
            end
            if (err_set) begin
                err_code <= err_nxt;
            end
            if (state == S_CHECK && csum_ok) begin
                data_valid <= 1'b1;
                busy       <= 1'b0;
                hum_int    <= frame_byte(shift_reg, BYTE_HUM_INT);
                hum_dec    <= frame_byte(shift_reg, BYTE_HUM_DEC);
                temp_int   <= frame_byte(shift_reg, BYTE_TEMP_INT);
                temp_dec   <= frame_byte(shift_reg, BYTE_TEMP_DEC);
            end
            if (state == S_ERR) begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dht11_frame_receiver.sv
`timescale 1ns/1ps
// Directed bench for the DHT11 reply decoder.
// Latency: checks exact strobe timing for nominal frames and the response timeout.
// Backpressure: n/a.
module tb_dht11_frame_receiver;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       start_done = 1'b0;
    logic       dht11_in   = 1'b1;
    logic       busy;
    logic       data_valid;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   nvalid = 0;
    int   nerr   = 0;
    int   valid_cyc = 0;
    int   err_cyc   = 0;
    int   t_fall    = 0;
    int   t0        = 0;
    int   n0        = 0;
    int   e0        = 0;
    logic valid_busy      = 1'b0;
    logic valid_busy_prev = 1'b0;
    logic busy_q          = 1'b0;

    dht11_frame_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .start_done (start_done),
        .dht11_in   (dht11_in),
        .busy       (busy),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid) begin
            nvalid++;
            valid_cyc       = cyc;
            valid_busy      = busy;
            valid_busy_prev = busy_q;
        end
        if (frame_err) begin
            nerr++;
            err_cyc = cyc;
        end
        busy_q = busy;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hold the line at v for n ticks (called and returning on a falling edge).
    task automatic line(input logic v, input int n);
        dht11_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse();
        start_done = 1'b1;
        @(negedge clk);
        start_done = 1'b0;
    endtask

    task automatic send_resp();
        line(1'b1, 20);
        line(1'b0, 80);
        line(1'b1, 80);
    endtask

    // Send bits [from,to) of f MSB first; bit extra_at gets a stray start_done in its low phase.
    task automatic send_bits(input logic [39:0] f, input int from, input int to,
                             input int hi0, input int hi1, input int extra_at);
        for (int i = from; i < to; i++) begin
            if (i == extra_at) begin
                dht11_in   = 1'b0;
                start_done = 1'b1;
                @(negedge clk);
                start_done = 1'b0;
                line(1'b0, 49);
            end else begin
                line(1'b0, 50);
            end
            line(1'b1, f[39-i] ? hi1 : hi0);
        end
    endtask

    task automatic run_frame(input logic [39:0] f, input int hi0, input int hi1, input int extra_at);
        start_pulse();
        send_resp();
        send_bits(f, 0, 40, hi0, hi1, extra_at);
        t_fall = cyc;
        line(1'b0, 50);
        line(1'b1, 20);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, data_valid, frame_err, err_code, hum_int, hum_dec, temp_int, temp_dec}, 64'd0);
        rst = 1'b1;
        line(1'b1, 5);

        // Nominal frame 37 00 18 05 / 54
        n0 = nvalid; e0 = nerr;
        run_frame(40'h37_00_18_05_54, 27, 70, -1);
        chk("nom_valid_count", nvalid - n0, 1);
        chk("nom_err_count", nerr - e0, 0);
        chk("nom_hum_int", hum_int, 8'd55);
        chk("nom_hum_dec", hum_dec, 8'd0);
        chk("nom_temp_int", temp_int, 8'd24);
        chk("nom_temp_dec", temp_dec, 8'd5);
        chk("nom_err_code", err_code, 2'd0);
        chk("nom_busy_at_valid", valid_busy, 1'b0);
        chk("nom_busy_before_valid", valid_busy_prev, 1'b1);
        // 2 synchroniser flops, decode edge, CHECK edge.
        chk("nom_latency", valid_cyc - t_fall, 4);

        // Bad checksum keeps previous data
        n0 = nvalid; e0 = nerr;
        run_frame(40'h37_00_18_05_55, 27, 70, -1);
        chk("csum_err_count", nerr - e0, 1);
        chk("csum_valid_count", nvalid - n0, 0);
        chk("csum_err_code", err_code, 2'd3);
        chk("csum_data_kept", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001805);
        chk("csum_busy", busy, 1'b0);

        // Checksum wraps modulo 256
        n0 = nvalid;
        run_frame(40'hFF_FF_02_00_00, 27, 70, -1);
        chk("wrap_valid_count", nvalid - n0, 1);
        chk("wrap_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'hFFFF0200);

        // No response: line stays high
        e0 = nerr;
        t0 = cyc;
        start_pulse();
        line(1'b1, 250);
        chk("resp_to_err_count", nerr - e0, 1);
        chk("resp_to_err_code", err_code, 2'd1);
        // Accept edge, 200-count compare, ERR entry edge, strobe edge.
        chk("resp_to_timing", err_cyc - t0, 203);
        chk("resp_to_data_kept", {hum_int, hum_dec, temp_int, temp_dec}, 32'hFFFF0200);

        // Line stuck low during bit 10
        e0 = nerr; n0 = nvalid;
        start_pulse();
        send_resp();
        send_bits(40'h37_00_18_05_54, 0, 10, 27, 70, -1);
        line(1'b0, 250);
        line(1'b1, 20);
        chk("bit_to_err_count", nerr - e0, 1);
        chk("bit_to_valid_count", nvalid - n0, 0);
        chk("bit_to_err_code", err_code, 2'd2);
        chk("bit_to_data_kept", {hum_int, hum_dec, temp_int, temp_dec}, 32'hFFFF0200);

        // Threshold boundary: 50-tick highs are 0, 51-tick highs are 1
        n0 = nvalid;
        run_frame(40'hA5_5A_0F_F0_FE, 50, 51, -1);
        chk("bound_valid_count", nvalid - n0, 1);
        chk("bound_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'hA55A0FF0);
        chk("bound_err_code", err_code, 2'd0);

        // Reset during bit 20
        n0 = nvalid; e0 = nerr;
        start_pulse();
        send_resp();
        send_bits(40'h37_00_18_05_54, 0, 20, 27, 70, -1);
        line(1'b0, 10);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b0;
        dht11_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_reset_outputs", {busy, data_valid, frame_err, err_code, hum_int, hum_dec, temp_int, temp_dec}, 64'd0);
        rst = 1'b1;
        line(1'b1, 20);
        chk("mid_no_strobes", {nvalid - n0, nerr - e0}, 64'd0);

        // Fresh frame with a stray start_done at bit 5
        run_frame(40'h37_00_18_05_54, 27, 70, 5);
        chk("post_valid_count", nvalid - n0, 1);
        chk("post_err_count", nerr - e0, 0);
        chk("post_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001805);
        chk("post_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
